// File: rtl/oven_timer_ctrl.sv
// oven_timer_ctrl: MM:SS keypad setpoint, cook-cycle FSM and 4-digit scanned display driver
module oven_timer_ctrl #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int SCAN_DIV   = 50_000,
  parameter int BEEP_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit_in,
  input  logic       digit_load,
  input  logic       start,
  input  logic       pause_cancel,
  input  logic       door_open,
  output logic [3:0] seg_code,
  output logic [3:0] an_sel,
  output logic       heater_on,
  output logic       done_beep
);
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int BW = $clog2(BEEP_TICKS + 1);
  typedef enum logic [1:0] {IDLE, COOK, PAUSE, DONE} state_t;
  state_t st;
  logic [3:0] m1, m0, s1, s0, d1, d0, e1, e0, dig, code;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] scnt;
  logic [BW-1:0] bcnt;
  logic [1:0] slot, slot_nx;
  logic blink, tick, wrap, zero, bs1, dz;
  always_comb begin
    tick = tcnt == TW'(TICK_DIV - 1);
    wrap = scnt == SW'(SCAN_DIV - 1);
    slot_nx = wrap ? slot + 2'd1 : slot;
    zero = {m1, m0, s1, s0} == 16'd0;
    e0 = s0 != 4'd0 ? s0 - 4'd1 : 4'd9;
    e1 = s0 != 4'd0 ? s1 : (s1 != 4'd0 ? s1 - 4'd1 : 4'd5);
    bs1 = s0 == 4'd0 && s1 == 4'd0;
    d0 = bs1 ? (m0 != 4'd0 ? m0 - 4'd1 : 4'd9) : m0;
    d1 = bs1 && m0 == 4'd0 ? m1 - 4'd1 : m1;
    dz = {d1, d0, e1, e0} == 16'd0;
    dig = slot_nx == 2'd0 ? s0 : slot_nx == 2'd1 ? s1 : slot_nx == 2'd2 ? m0 : m1;
    code = st == DONE ? 4'd0 :
           (st == PAUSE && blink) ? 4'd11 :
           (st == IDLE && zero && slot_nx != 2'd0) ? 4'd11 :
           (slot_nx == 2'd3 && m1 == 4'd0) ? 4'd11 : dig;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      {m1, m0, s1, s0} <= '0;
      tcnt <= '0;
      scnt <= '0;
      bcnt <= '0;
      slot <= '0;
      blink <= 1'b0;
      seg_code <= 4'd0;
      an_sel <= 4'b1110;
      heater_on <= 1'b0;
      done_beep <= 1'b0;
    end else begin
      tcnt <= tick ? '0 : tcnt + 1'b1;
      scnt <= wrap ? '0 : scnt + 1'b1;
      slot <= slot_nx;
      seg_code <= code;
      an_sel <= ~(4'b0001 << slot_nx);
      heater_on <= 1'b0;
      done_beep <= 1'b0;
      case (st)
        IDLE:
          if (pause_cancel) {m1, m0, s1, s0} <= '0;
          else if (start && !zero && !door_open) begin
            st <= COOK;
            tcnt <= '0;
            heater_on <= 1'b1;
          end else if (digit_load) {m1, m0, s1, s0} <= {m0, s1, s0, digit_in > 4'd9 ? 4'd9 : digit_in};
        COOK:
          if (door_open || pause_cancel) st <= PAUSE;
          else if (tick && dz) begin
            {m1, m0, s1, s0} <= '0;
            st <= DONE;
            bcnt <= '0;
            done_beep <= 1'b1;
          end else begin
            heater_on <= 1'b1;
            if (tick) {m1, m0, s1, s0} <= {d1, d0, e1, e0};
          end
        PAUSE:
          if (pause_cancel) begin
            st <= IDLE;
            {m1, m0, s1, s0} <= '0;
            blink <= 1'b0;
          end else if (start && !door_open) begin
            st <= COOK;
            tcnt <= '0;
            heater_on <= 1'b1;
            blink <= 1'b0;
          end else if (tick) blink <= ~blink;
        DONE:
          if (pause_cancel || (tick && bcnt == BW'(BEEP_TICKS - 1))) st <= IDLE;
          else begin
            done_beep <= 1'b1;
            if (tick) bcnt <= bcnt + 1'b1;
          end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_oven_timer_ctrl.sv
// tb_oven_timer_ctrl: directed checks of entry, countdown, completion, pause/door, cancel and reset
module tb_oven_timer_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] digit_in = '0;
  logic digit_load = 1'b0, start = 1'b0, pause_cancel = 1'b0, door_open = 1'b0;
  logic [3:0] seg_code, an_sel;
  logic heater_on, done_beep;
  int n_cmp = 0, n_bad = 0;
  logic [15:0] disp;
  oven_timer_ctrl #(.TICK_DIV(10), .SCAN_DIV(4), .BEEP_TICKS(3)) dut (
    .clk(clk), .rst_n(rst_n), .digit_in(digit_in), .digit_load(digit_load), .start(start),
    .pause_cancel(pause_cancel), .door_open(door_open), .seg_code(seg_code), .an_sel(an_sel),
    .heater_on(heater_on), .done_beep(done_beep)
  );
  always #5 clk = ~clk;
  wire [15:0] tm = {dut.m1, dut.m0, dut.s1, dut.s0};
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic load(input logic [3:0] d);
    digit_in = d;
    digit_load = 1'b1;
    cyc(1);
    digit_load = 1'b0;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask
  task automatic pulse_cancel();
    pause_cancel = 1'b1;
    cyc(1);
    pause_cancel = 1'b0;
  endtask
  task automatic read_disp(output logic [15:0] v);
    logic [3:0] c [4];
    for (int i = 0; i < 4; i++) c[i] = 4'hf;
    repeat (16) begin
      cyc(1);
      case (an_sel)
        4'b1110: c[0] = seg_code;
        4'b1101: c[1] = seg_code;
        4'b1011: c[2] = seg_code;
        4'b0111: c[3] = seg_code;
        default: ;
      endcase
    end
    v = {c[3], c[2], c[1], c[0]};
  endtask
  function automatic int exp_code(input logic [3:0] an, input logic [15:0] t);
    case (an)
      4'b1110: return int'(t[3:0]);
      4'b1101: return int'(t[7:4]);
      4'b1011: return int'(t[11:8]);
      4'b0111: return t[15:12] == 4'd0 ? 11 : int'(t[15:12]);
      default: return 15;
    endcase
  endfunction
  initial begin
    cyc(3);
    chk("rst_seg", seg_code, 0);
    chk("rst_an", an_sel, 4'b1110);
    chk("rst_heat", heater_on, 0);
    chk("rst_beep", done_beep, 0);
    rst_n = 1'b1;
    cyc(1);
    chk("idle_state", int'(dut.st), 0);
    load(4'd1); load(4'd2); load(4'd3); load(4'd12);
    chk("entry_time", tm, 16'h1239);
    cyc(1);
    read_disp(disp);
    chk("entry_scan", disp, 16'h1239);
    pulse_cancel();
    chk("idle_clear", tm, 16'h0000);
    load(4'd1); load(4'd0); load(4'd0);
    chk("load_0100", tm, 16'h0100);
    pulse_start();
    chk("cook_state", int'(dut.st), 1);
    chk("cook_heat0", heater_on, 1);
    cyc(9);
    chk("pre_tick", tm, 16'h0100);
    cyc(1);
    chk("borrow_59", tm, 16'h0059);
    chk("cook_heat10", heater_on, 1);
    cyc(10);
    chk("dec_58", tm, 16'h0058);
    chk("cook_heat20", heater_on, 1);
    start = 1'b1;
    pause_cancel = 1'b1;
    cyc(1);
    start = 1'b0;
    pause_cancel = 1'b0;
    chk("prio_pause", int'(dut.st), 2);
    chk("prio_heat", heater_on, 0);
    chk("prio_hold", tm, 16'h0058);
    pulse_cancel();
    chk("cancel_idle", int'(dut.st), 0);
    chk("cancel_time", tm, 16'h0000);
    cyc(1);
    read_disp(disp);
    chk("zero_scan", disp, 16'hbbb0);
    pulse_start();
    chk("start_zero", int'(dut.st), 0);
    chk("start_zero_heat", heater_on, 0);
    load(4'd2);
    pulse_start();
    cyc(19);
    chk("c19_state", int'(dut.st), 1);
    chk("c19_time", tm, 16'h0001);
    chk("c19_beep", done_beep, 0);
    chk("c19_heat", heater_on, 1);
    cyc(1);
    chk("done_state", int'(dut.st), 3);
    chk("done_time", tm, 16'h0000);
    chk("done_beep_up", done_beep, 1);
    chk("done_heat", heater_on, 0);
    cyc(5);
    chk("done_seg", seg_code, 0);
    cyc(24);
    chk("beep_49", done_beep, 1);
    chk("done_49", int'(dut.st), 3);
    cyc(1);
    chk("beep_50", done_beep, 0);
    chk("auto_idle", int'(dut.st), 0);
    load(4'd3); load(4'd0);
    pulse_start();
    cyc(14);
    chk("c14_heat", heater_on, 1);
    door_open = 1'b1;
    cyc(1);
    chk("door_pause", int'(dut.st), 2);
    chk("door_heat", heater_on, 0);
    chk("door_hold", tm, 16'h0029);
    pulse_start();
    chk("door_start_ign", int'(dut.st), 2);
    cyc(9);
    chk("blink_on", seg_code, 11);
    cyc(10);
    chk("blink_off", seg_code, exp_code(an_sel, 16'h0029));
    door_open = 1'b0;
    pulse_start();
    chk("resume_state", int'(dut.st), 1);
    chk("resume_heat", heater_on, 1);
    cyc(9);
    chk("resume_pre", tm, 16'h0029);
    cyc(1);
    chk("resume_dec", tm, 16'h0028);
    cyc(2);
    chk("resume_seg", seg_code, exp_code(an_sel, 16'h0028));
    pulse_cancel();
    pulse_cancel();
    load(4'd3); load(4'd0);
    pulse_start();
    cyc(3);
    chk("pre_rst_time", tm, 16'h0030);
    chk("pre_rst_heat", heater_on, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_heat", heater_on, 0);
    chk("arst_an", an_sel, 4'b1110);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    chk("post_rst_state", int'(dut.st), 0);
    chk("post_rst_time", tm, 16'h0000);
    chk("post_rst_heat", heater_on, 0);
    chk("post_rst_seg", seg_code, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/oven_timer_ctrl.md
# oven_timer_ctrl

Countdown controller and display scheduler for the oven simulator. It accepts keypad digits into a four-digit MM:SS setpoint and runs the cook cycle FSM (idle/cook/pause/done) that drives the heater and the completion beeper. It time-multiplexes a single shared BCD-to-seven-segment decoder across four common-anode digits by presenting one 4-bit digit code per scan slot.

## Interface
- TICK_DIV, 50_000_000: clk cycles per countdown tick (1 s).
- SCAN_DIV, 50_000: clk cycles per display scan slot.
- BEEP_TICKS, 3: ticks done_beep stays high in DONE.
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- digit_in  in  4  keypad digit value; values >9 load as 9.
- digit_load  in  1  one-cycle pulse: shift digit_in into setpoint.
- start  in  1  one-cycle pulse: begin or resume cooking.
- pause_cancel  in  1  one-cycle pulse: pause, or clear when paused or done.
- door_open  in  1  level: door is open.
- seg_code  out  4  code to the shared decoder. 0–9 is a digit; 11 is blank.
- an_sel  out  4  active-low one-hot digit enable: [0]=S0, [1]=S1, [2]=M0, [3]=M1.
- heater_on  out  1  high only in COOK.
- done_beep  out  1  high for the first BEEP_TICKS ticks of DONE.

## Operation
- Time register: four BCD digits M1 M0 S1 S0. All are 0 at reset.
- States: IDLE, COOK, PAUSE, DONE. Reset state is IDLE.
- IDLE
  - digit_load shifts the digits: M1←M0, M0←S1, S1←S0, S0←min(digit_in, 9).
  - start with time≠0 and door closed → COOK.
  - start with time=0 or door open is ignored.
  - pause_cancel clears the time to 0000.
- COOK
  - Decrement on each tick.
  - BCD borrow chain: S0 9→0; on S0 borrow, S1 5→0. An entered S1 of 6–9 counts down normally; on S1 borrow it wraps to 5. M0 9→0, M1 9→0.
  - The decrement that reaches 0000 moves to DONE on the same edge.
  - door_open or pause_cancel → PAUSE, with the time held.
- PAUSE
  - start with door closed → COOK.
  - pause_cancel → IDLE with the time cleared.
  - digit_load is ignored.
- DONE
  - Display shows 0000.
  - After BEEP_TICKS ticks → IDLE automatically.
  - pause_cancel → IDLE immediately.
- Priority in one cycle: door_open > pause_cancel > start > digit_load. digit_load is never applied in a cycle where start is accepted.
- Tick counter
  - Free-runs 0..TICK_DIV-1.
  - Zeroed on every transition into COOK, so the first decrement is exactly TICK_DIV cycles after start is accepted.
- Display scan
  - Scan counter 0..SCAN_DIV-1. On wrap, the slot index advances 0→1→2→3→0.
  - seg_code shows the selected digit, with these exceptions:
  - M1 slot shows 11 when M1=0 (leading blank).
  - In PAUSE, all slots show 11 when the blink flag is 1. The blink flag toggles every tick in PAUSE and clears on PAUSE exit.
  - In IDLE with time=0000, only the S0 slot shows 0; M1, M0 and S1 show 11.
- heater_on is forced low in any cycle where door_open=1, regardless of state.

## Timing
- All outputs are registered.
- Reset values: seg_code=0, an_sel=4'b1110, heater_on=0, done_beep=0. Slot index, counters and blink flag are all 0.
- State change: one cycle after the accepting input pulse.
  - heater_on rises on the same edge as the COOK entry.
  - heater_on falls on the same edge as the COOK exit.
- seg_code and an_sel update together on the scan-wrap edge. They also update on any time or state change within one cycle, so no slot ever shows a stale digit for more than one cycle.
- done_beep rises on the DONE entry edge. It falls after BEEP_TICKS ticks or on leaving DONE, whichever is first.
- Reset asserted mid-cook: immediate IDLE, time cleared, heater_on low asynchronously.
- Inputs are synchronous and debounced upstream. Pulse inputs are exactly one cycle wide.

## Test plan
Bench parameters: TICK_DIV=10, SCAN_DIV=4, BEEP_TICKS=3.
- Entry and saturation: load 1,2,3,12 → time 1239. Scan yields codes 9,3,2,1 on an_sel 1110,1101,1011,0111.
- Borrow chain: load 0100, start → 0059 after 10 cycles, 0058 at 20. heater_on=1 throughout.
- Completion: from 0002, start → DONE at cycle 20 (counted from the start-accept edge). done_beep=1 for 30 cycles, then IDLE. heater_on=0 from DONE entry.
- Door and pause
  - door_open at cycle 15 of COOK → PAUSE, heater_on=0 the next cycle, display blinks every 10 cycles.
  - start with door still open → ignored.
  - Close door, start → COOK, next decrement 10 cycles later.
- Priority and cancel
  - start+pause_cancel in the same cycle in COOK → PAUSE.
  - pause_cancel in PAUSE → IDLE, 0000, codes 11,11,11,0.
  - start at 0000 → stays IDLE.
- Async reset mid-COOK at 0030: rst_n low → heater_on=0 and an_sel=1110 without a clock edge. After release: IDLE, time 0000.
